// File: rtl/hilo_mul_sequencer.sv
// hilo_mul_sequencer: iterative shift-add MULT/MADD/MSUB sequencer owning the HI/LO pair.
// rev 1.0
`default_nettype none

module hilo_mul_sequencer #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic [1:0]         kind_q;
  logic               sign_q;
  logic               busy_q;
  logic               done_q;

  logic               w_signed;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [2*WIDTH-1:0] w_prod, w_hilo, w_res;

  // Even opcodes are the signed variants; magnitudes are unsigned so 2^(W-1) fits.
  assign w_signed = ~op_i[0];
  assign w_a_mag  = (w_signed && a_i[WIDTH-1]) ? -a_i : a_i;
  assign w_b_mag  = (w_signed && b_i[WIDTH-1]) ? -b_i : b_i;

  always_comb begin
    acc_d = acc_q;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (mplier_q[k]) acc_d = acc_d + (mcand_q << k);
    end
  end

  always_comb begin
    w_prod = sign_q ? -acc_q : acc_q;
    w_hilo = {hi_q, lo_q};
    case (kind_q)
      2'b01:   w_res = w_hilo + w_prod;
      2'b10:   w_res = w_hilo - w_prod;
      default: w_res = w_prod;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      kind_q   <= '0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            if (op_i[2:1] == 2'b11) begin
              if (op_i[0]) lo_q <= a_i;
              else         hi_q <= a_i;
              done_q <= 1'b1;
            end else begin
              kind_q   <= op_i[2:1];
              sign_q   <= w_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
              mcand_q  <= {{WIDTH{1'b0}}, w_a_mag};
              mplier_q <= w_b_mag;
              acc_q    <= '0;
              cnt_q    <= CW'(N - 1);
              busy_q   <= 1'b1;
              state_q  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush_i) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << BITS_PER_CYCLE;
            mplier_q <= mplier_q >> BITS_PER_CYCLE;
            if (cnt_q == '0) state_q <= S_FINISH;
            else             cnt_q   <= cnt_q - CW'(1);
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (!flush_i) begin
            {hi_q, lo_q} <= w_res;
            done_q       <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

`default_nettype wire
